// File: rtl/lfsr_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg
// Shared definitions for the parameterised LFSR block:
//   - lfsr_state_e : controller state encoding (IDLE, RUN, DONE, LOCKED)
//   - TAPS_W4      : default feedback mask, maximal-length for a 4-bit register
// -----------------------------------------------------------------------------
package lfsr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,  // no seed loaded yet
    ST_RUN    = 2'd1,  // stepping and measuring the period
    ST_DONE   = 2'd2,  // period captured, register keeps stepping
    ST_LOCKED = 2'd3   // all-zero state, stepping suppressed
  } lfsr_state_e;

  localparam logic [3:0] TAPS_W4 = 4'b0011;

endpackage

// File: rtl/lfsr_next.sv
// -----------------------------------------------------------------------------
// lfsr_next
// Combinational step rule of the LFSR: right shift with the XOR-reduced
// feedback (state AND taps) inserted at the MSB.
// Ports:
//   i_state : current register contents
//   i_taps  : feedback mask
//   o_next  : next register contents
// -----------------------------------------------------------------------------
module lfsr_next #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_state,
  input  logic [WIDTH-1:0] i_taps,
  output logic [WIDTH-1:0] o_next
);

  logic w_fb;

  assign w_fb   = ^(i_state & i_taps);
  assign o_next = {w_fb, i_state[WIDTH-1:1]};

endmodule

// File: rtl/lfsr_param.sv
// -----------------------------------------------------------------------------
// lfsr_param
// Parameterised Fibonacci-style LFSR with period measurement.
// After a non-zero seed is loaded the register steps on every enabled cycle;
// the number of steps until the seed recurs is reported on period. If the
// step counter saturates without a recurrence, period=0 is reported instead.
// A zero seed locks the register (no stepping) until the next load or reset.
// Ports:
//   clk          : clock, rising edge
//   reset        : synchronous active-high reset
//   seed         : value captured on load
//   load         : capture seed, restart measurement (wins over enable)
//   enable       : advance one step per cycle
//   state        : current register contents (registered)
//   bit_out      : state[0]
//   lock_up      : high while state is all-zero
//   period       : measured cycle length, 0 = no recurrence
//   period_valid : period holds a result for the current seed
// -----------------------------------------------------------------------------
module lfsr_param
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_W4)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] seed,
  input  logic             load,
  input  logic             enable,
  output logic [WIDTH-1:0] state,
  output logic             bit_out,
  output logic             lock_up,
  output logic [WIDTH-1:0] period,
  output logic             period_valid
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  lfsr_state_e      r_fsm;
  lfsr_state_e      w_fsm_nxt;
  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] w_state_nxt;
  logic [WIDTH-1:0] r_ref;
  logic [WIDTH-1:0] w_ref_nxt;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] r_period;
  logic [WIDTH-1:0] w_period_nxt;
  logic             r_period_valid;
  logic             w_period_valid_nxt;
  logic [WIDTH-1:0] w_step;

  lfsr_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .i_state (r_state),
    .i_taps  (TAPS),
    .o_next  (w_step)
  );

  // Next-state and datapath decode; load overrides every FSM state.
  always_comb begin
    w_fsm_nxt          = r_fsm;
    w_state_nxt        = r_state;
    w_ref_nxt          = r_ref;
    w_cnt_nxt          = r_cnt;
    w_period_nxt       = r_period;
    w_period_valid_nxt = r_period_valid;

    if (load) begin
      w_state_nxt  = seed;
      w_ref_nxt    = seed;
      w_cnt_nxt    = ALL_ZERO;
      w_period_nxt = ALL_ZERO;
      if (seed == ALL_ZERO) begin
        // A zero seed can never leave zero: report "no recurrence" at once.
        w_fsm_nxt          = ST_LOCKED;
        w_period_valid_nxt = 1'b1;
      end else begin
        w_fsm_nxt          = ST_RUN;
        w_period_valid_nxt = 1'b0;
      end
    end else begin
      case (r_fsm)
        ST_RUN: begin
          if (enable) begin
            w_state_nxt = w_step;
            if (w_step == r_ref) begin
              // r_cnt counts the steps already taken; this one is step r_cnt+1.
              w_period_nxt       = r_cnt + ONE;
              w_period_valid_nxt = 1'b1;
              w_fsm_nxt          = ST_DONE;
            end else if (r_cnt == ALL_ONES) begin
              w_period_nxt       = ALL_ZERO;
              w_period_valid_nxt = 1'b1;
              w_fsm_nxt          = ST_DONE;
            end else begin
              w_cnt_nxt = r_cnt + ONE;
            end
          end else begin
            w_state_nxt = r_state;
          end
        end
        ST_DONE: begin
          if (enable) begin
            w_state_nxt = w_step;
          end else begin
            w_state_nxt = r_state;
          end
        end
        ST_IDLE:   w_state_nxt = r_state;
        ST_LOCKED: w_state_nxt = r_state;
        default:   w_fsm_nxt   = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fsm          <= ST_IDLE;
      r_state        <= ALL_ONES;
      r_ref          <= ALL_ONES;
      r_cnt          <= ALL_ZERO;
      r_period       <= ALL_ZERO;
      r_period_valid <= 1'b0;
    end else begin
      r_fsm          <= w_fsm_nxt;
      r_state        <= w_state_nxt;
      r_ref          <= w_ref_nxt;
      r_cnt          <= w_cnt_nxt;
      r_period       <= w_period_nxt;
      r_period_valid <= w_period_valid_nxt;
    end
  end

  assign state        = r_state;
  assign bit_out      = r_state[0];
  assign lock_up      = (r_state == ALL_ZERO);
  assign period       = r_period;
  assign period_valid = r_period_valid;

endmodule

// File: tb/tb_lfsr_param.sv
// -----------------------------------------------------------------------------
// tb_lfsr_param
// Table-driven bench for lfsr_param. dut1 uses the default 4-bit maximal-length
// taps, dut2 uses the non-invertible mask 4'b0010. Each vector's expected
// outputs are queued when the vector is driven and compared one edge later.
// -----------------------------------------------------------------------------
module tb_lfsr_param;

  typedef struct {
    logic       sel;   // 0 = dut1, 1 = dut2
    logic       rst;
    logic       ld;
    logic       en;
    logic [3:0] seed;
    logic [3:0] st;
    logic [3:0] per;
    logic       vld;
    logic       lk;
    string      tag;
  } vec_t;

  logic       clk;
  logic       d1_rst, d1_ld, d1_en;
  logic [3:0] d1_seed, d1_state, d1_period;
  logic       d1_bit, d1_lock, d1_valid;
  logic       d2_rst, d2_ld, d2_en;
  logic [3:0] d2_seed, d2_state, d2_period;
  logic       d2_bit, d2_lock, d2_valid;

  int n_checks = 0;
  int n_errors = 0;

  vec_t tbl[$];
  vec_t sb[$];
  logic [3:0] seq15 [15];
  logic [3:0] pat2  [3];

  lfsr_param #(.WIDTH(4)) dut1 (
    .clk          (clk),
    .reset        (d1_rst),
    .seed         (d1_seed),
    .load         (d1_ld),
    .enable       (d1_en),
    .state        (d1_state),
    .bit_out      (d1_bit),
    .lock_up      (d1_lock),
    .period       (d1_period),
    .period_valid (d1_valid)
  );

  lfsr_param #(.WIDTH(4), .TAPS(4'b0010)) dut2 (
    .clk          (clk),
    .reset        (d2_rst),
    .seed         (d2_seed),
    .load         (d2_ld),
    .enable       (d2_en),
    .state        (d2_state),
    .bit_out      (d2_bit),
    .lock_up      (d2_lock),
    .period       (d2_period),
    .period_valid (d2_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void add(input logic sel, input logic rst, input logic ld,
                              input logic en, input logic [3:0] seed,
                              input logic [3:0] st, input logic [3:0] per,
                              input logic vld, input logic lk, input string tag);
    vec_t v;
    v.sel = sel; v.rst = rst; v.ld = ld; v.en = en; v.seed = seed;
    v.st = st; v.per = per; v.vld = vld; v.lk = lk; v.tag = tag;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string tag, input string fld,
                     input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s.%s: got %b expected %b", tag, fld, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    d1_rst = 1'b0; d1_ld = 1'b0; d1_en = 1'b0; d1_seed = 4'h0;
    d2_rst = 1'b1; d2_ld = 1'b0; d2_en = 1'b0; d2_seed = 4'h0;
    if (v.sel == 1'b0) begin
      d1_rst = v.rst; d1_ld = v.ld; d1_en = v.en; d1_seed = v.seed;
    end else begin
      d2_rst = v.rst; d2_ld = v.ld; d2_en = v.en; d2_seed = v.seed;
    end
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (e.sel == 1'b0) begin
      chk(e.tag, "state",  d1_state,         e.st);
      chk(e.tag, "bit",    {3'b000, d1_bit}, {3'b000, e.st[0]});
      chk(e.tag, "period", d1_period,        e.per);
      chk(e.tag, "valid",  {3'b000, d1_valid}, {3'b000, e.vld});
      chk(e.tag, "lock",   {3'b000, d1_lock},  {3'b000, e.lk});
    end else begin
      chk(e.tag, "state",  d2_state,         e.st);
      chk(e.tag, "bit",    {3'b000, d2_bit}, {3'b000, e.st[0]});
      chk(e.tag, "period", d2_period,        e.per);
      chk(e.tag, "valid",  {3'b000, d2_valid}, {3'b000, e.vld});
      chk(e.tag, "lock",   {3'b000, d2_lock},  {3'b000, e.lk});
    end
  endtask

  initial begin
    d1_rst = 1'b1; d1_ld = 1'b0; d1_en = 1'b0; d1_seed = 4'h0;
    d2_rst = 1'b1; d2_ld = 1'b0; d2_en = 1'b0; d2_seed = 4'h0;

    // Maximal-length orbit of taps 4'b0011 starting after 1111.
    seq15 = '{4'b0111, 4'b0011, 4'b0001, 4'b1000, 4'b0100, 4'b0010, 4'b1001,
              4'b1100, 4'b0110, 4'b1011, 4'b0101, 4'b1010, 4'b1101, 4'b1110,
              4'b1111};
    // Orbit of taps 4'b0010 after seed 1000: 0100, 0010, 1001, 0100, ...
    pat2  = '{4'b0100, 4'b0010, 4'b1001};

    // Reset, then enable ignored in IDLE.
    add(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'hF, 4'h0, 1'b0, 1'b0, "reset");
    for (int i = 0; i < 3; i++)
      add(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'hF, 4'h0, 1'b0, 1'b0, $sformatf("idle_en%0d", i));

    // Full period from seed 1111.
    add(1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 4'hF, 4'h0, 1'b0, 1'b0, "load_f");
    for (int k = 1; k <= 15; k++)
      add(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, seq15[k-1], (k == 15) ? 4'd15 : 4'd0,
          (k == 15), 1'b0, $sformatf("maxlen_step%0d", k));
    for (int k = 0; k < 2; k++)
      add(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, seq15[k], 4'd15, 1'b1, 1'b0, $sformatf("done_step%0d", k));
    add(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, seq15[1], 4'd15, 1'b1, 1'b0, "done_hold");

    // Load with enable in DONE: load wins, measurement restarts from 1010.
    add(1'b0, 1'b0, 1'b1, 1'b1, 4'hA, 4'hA, 4'h0, 1'b0, 1'b0, "load_a_en");
    for (int k = 1; k <= 15; k++)
      add(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, seq15[(11 + k) % 15], (k == 15) ? 4'd15 : 4'd0,
          (k == 15), 1'b0, $sformatf("seed_a_step%0d", k));

    // Zero seed locks up; enable has no effect; a non-zero load resumes.
    add(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, "load_zero");
    for (int k = 0; k < 10; k++)
      add(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, $sformatf("locked_en%0d", k));
    add(1'b0, 1'b0, 1'b1, 1'b1, 4'h9, 4'h9, 4'h0, 1'b0, 1'b0, "unlock_9");
    add(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'hC, 4'h0, 1'b0, 1'b0, "run_after_unlock");
    add(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'hC, 4'h0, 1'b0, 1'b0, "run_hold");

    // Reset mid-measurement, and reset winning over load.
    add(1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 4'hF, 4'h0, 1'b0, 1'b0, "reload_f");
    for (int k = 1; k <= 6; k++)
      add(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, seq15[k-1], 4'h0, 1'b0, 1'b0, $sformatf("pre_rst_step%0d", k));
    add(1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 4'hF, 4'h0, 1'b0, 1'b0, "mid_reset");
    add(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'hF, 4'h0, 1'b0, 1'b0, "idle_after_reset");
    add(1'b0, 1'b1, 1'b1, 1'b1, 4'h5, 4'hF, 4'h0, 1'b0, 1'b0, "reset_over_load");

    // Non-invertible taps: the seed never recurs. Steps 1..15 leave the
    // counter at all-ones; the 16th step reports the no-recurrence result.
    add(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'hF, 4'h0, 1'b0, 1'b0, "d2_reset");
    add(1'b1, 1'b0, 1'b1, 1'b0, 4'h8, 4'h8, 4'h0, 1'b0, 1'b0, "d2_load_8");
    for (int k = 1; k <= 17; k++)
      add(1'b1, 1'b0, 1'b0, 1'b1, 4'h0, pat2[(k-1) % 3], 4'h0, (k >= 16), 1'b0,
          $sformatf("norecur_step%0d", k));

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i]);

    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
